tt_um_hoene_activity_qual: RTL and testbench
============================================

// Module: tt_um_hoene_activity_qual
// PURPOSE
//   Input conditioning stage ahead of the input selector mux. Synchronises and
//   glitch-filters the two raw pad inputs, generates a rising-edge strobe on
//   in0 and qualifies in0 as "active" once enough edges arrive without a gap.
//   The clean signals feed the mux inputs. in0_active is the selection qualifier.
// PARAMETERS
//   SYNC_STAGES    2    flops in each input synchroniser (>=2)
//   FILT_LEN       3    consecutive stable cycles before filtered level changes (>=1)
//   EDGES_TO_LOCK  63   in0 rising edges needed in ACQUIRE to enter LOCKED (1..63)
//   TIMEOUT        255  max cycles between in0 rises before activity is lost (1..255)
// PORTS
//   clk          in   1  global clock
//   rst_n        in   1  reset, asynchronous assert, active low
//   in0_raw      in   1  asynchronous input 0 from pad
//   in1_raw      in   1  asynchronous input 1 from pad
//   enable       in   1  qualifier enable; low forces IDLE
//   in0_clean    out  1  synchronised, filtered in0
//   in1_clean    out  1  synchronised, filtered in1
//   in0_rise     out  1  one-cycle pulse on in0_clean 0->1
//   in0_active   out  1  high while state==LOCKED
//   lost         out  1  one-cycle pulse on LOCKED->ACQUIRE timeout
//   state        out  2  00 IDLE, 01 ACQUIRE, 10 LOCKED
//   edge_count   out  6  rises counted in current ACQUIRE/LOCKED run, saturating
// BEHAVIOUR
//   Reset: all flops 0. Outputs are 0, state=IDLE, edge_count=0, and the filter counters are 0.
//   Sync: SYNC_STAGES-deep flop chain per input. No logic between stages.
//   Filter, per input: fcnt counts cycles with sync_out != clean and clears when they are equal.
//     When sync_out != clean and fcnt == FILT_LEN-1: clean <= sync_out, fcnt <= 0.
//     Latency from a stable raw change to clean is SYNC_STAGES+FILT_LEN clock edges.
//     A pulse shorter than FILT_LEN cycles never reaches clean.
//   in0_rise: registered clean & ~clean_d. It asserts for exactly 1 cycle, one cycle after clean rises.
//   Gap timer (8 bit): clears on in0_rise. Otherwise it increments in ACQUIRE/LOCKED and saturates at TIMEOUT.
//   FSM, evaluated each clk:
//     IDLE:    enable=1 -> ACQUIRE. Timer=0, edge_count=0.
//     ACQUIRE: in0_rise -> edge_count+1. Reaching EDGES_TO_LOCK -> LOCKED in the same edge.
//              Timer==TIMEOUT with no rise -> stay in ACQUIRE, edge_count=0, timer=0.
//     LOCKED:  in0_rise -> edge_count+1, saturating at 63.
//              Timer==TIMEOUT -> ACQUIRE, lost=1 for 1 cycle, edge_count=0, timer=0.
//     Any state: enable=0 -> IDLE on the next edge. Counters clear. lost is not pulsed.
//   Priority: enable=0 > in0_rise > timeout. A rise coinciding with timeout wins.
//   in0_active is registered from state and goes high the cycle after entry to LOCKED.
//   Filters and sync run regardless of enable and state.
//   rst_n low mid-operation returns everything to the reset values immediately, without waiting for clk.
// TESTING
//   1. Reset, in0_raw=1 held -> in0_clean=1 exactly 5 edges later (2+3); in0_rise one pulse.
//   2. 2-cycle high glitch on in1_raw -> in1_clean stays 0; 3-cycle high -> in1_clean pulses.
//   3. enable=1, in0 square wave period 20 -> LOCKED after 63rd rise; in0_active=1 next cycle.
//   4. Stop in0 in LOCKED -> 255 cycles after last rise: lost=1 for 1 cycle, state=ACQUIRE, edge_count=0.
//   5. Rise aligned with timer==TIMEOUT -> no timeout; edge_count increments; drop enable -> IDLE next edge.
//   6. Assert rst_n low between clk edges while LOCKED -> outputs 0 immediately; relock needs 63 rises.

Source files
------------

// File: rtl/tt_um_hoene_activity_qual.sv
// Input conditioning ahead of the selector mux: per-input synchroniser and glitch
// filter, rising-edge strobe on in0, and an activity qualifier FSM for in0.
module tt_um_hoene_activity_qual #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned FILT_LEN      = 3,
    parameter int unsigned EDGES_TO_LOCK = 63,
    parameter int unsigned TIMEOUT       = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in0_raw,
    input  logic       in1_raw,
    input  logic       enable,
    output logic       in0_clean,
    output logic       in1_clean,
    output logic       in0_rise,
    output logic       in0_active,
    output logic       lost,
    output logic [1:0] state,
    output logic [5:0] edge_count
);

    localparam int unsigned FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ACQUIRE = 2'b01,
        LOCKED  = 2'b10
    } state_e;

    logic [1:0][SYNC_STAGES-1:0] sync_q, sync_d;
    logic [1:0][FW-1:0]          fcnt_q, fcnt_d;
    logic [1:0]                  clean_q, clean_d;
    logic [1:0]                  raw;
    logic                        clean_dly_q, clean_dly_d;
    logic                        rise_q, rise_d;
    logic [7:0]                  timer_q, timer_d;
    logic [5:0]                  cnt_q, cnt_d;
    state_e                      state_q, state_d;
    logic                        lost_q, lost_d;
    logic                        active_q, active_d;
    logic                        timeout;
    logic [6:0]                  cnt_inc;

    // Index 0 is in0, index 1 is in1; both paths are identical.
    always_comb begin
        raw     = {in1_raw, in0_raw};
        sync_d  = sync_q;
        fcnt_d  = '0;
        clean_d = clean_q;
        for (int unsigned i = 0; i < 2; i++) begin
            sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], raw[i]};
            if (sync_q[i][SYNC_STAGES-1] != clean_q[i]) begin
                if (fcnt_q[i] == FW'(FILT_LEN - 1)) begin
                    clean_d[i] = sync_q[i][SYNC_STAGES-1];
                end else begin
                    fcnt_d[i] = fcnt_q[i] + 1'b1;
                end
            end
        end
        clean_dly_d = clean_q[0];
        rise_d      = clean_q[0] & ~clean_dly_q;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        timer_d  = timer_q;
        lost_d   = 1'b0;
        timeout  = (timer_q == 8'(TIMEOUT));
        cnt_inc  = {1'b0, cnt_q} + 7'd1;
        active_d = (state_q == LOCKED);
        // enable low outranks a rise, which outranks a timeout.
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            timer_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ACQUIRE;
                    cnt_d   = '0;
                    timer_d = '0;
                end
                ACQUIRE: begin
                    if (rise_q) begin
                        timer_d = '0;
                        cnt_d   = cnt_inc[5:0];
                        if (cnt_inc == 7'(EDGES_TO_LOCK)) state_d = LOCKED;
                    end else if (timeout) begin
                        cnt_d   = '0;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 8'd1;
                    end
                end
                LOCKED: begin
                    if (rise_q) begin
                        timer_d = '0;
                        if (cnt_q != 6'd63) cnt_d = cnt_inc[5:0];
                    end else if (timeout) begin
                        state_d = ACQUIRE;
                        lost_d  = 1'b1;
                        cnt_d   = '0;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 8'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    timer_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= '0;
            fcnt_q      <= '0;
            clean_q     <= '0;
            clean_dly_q <= 1'b0;
            rise_q      <= 1'b0;
            timer_q     <= '0;
            cnt_q       <= '0;
            state_q     <= IDLE;
            lost_q      <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            fcnt_q      <= fcnt_d;
            clean_q     <= clean_d;
            clean_dly_q <= clean_dly_d;
            rise_q      <= rise_d;
            timer_q     <= timer_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            lost_q      <= lost_d;
            active_q    <= active_d;
        end
    end

    assign in0_clean  = clean_q[0];
    assign in1_clean  = clean_q[1];
    assign in0_rise   = rise_q;
    assign in0_active = active_q;
    assign lost       = lost_q;
    assign state      = state_q;
    assign edge_count = cnt_q;

endmodule

// File: tb/tb_tt_um_hoene_activity_qual.sv
// Scoreboard bench for tt_um_hoene_activity_qual: stimulus queues expected values
// stamped with a clock-edge index; a negedge monitor pops and compares them.
module tb_tt_um_hoene_activity_qual;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in0_raw, in1_raw, enable;
    logic       in0_clean, in1_clean, in0_rise, in0_active, lost;
    logic [1:0] state;
    logic [5:0] edge_count;

    tt_um_hoene_activity_qual #(
        .SYNC_STAGES  (2),
        .FILT_LEN     (3),
        .EDGES_TO_LOCK(63),
        .TIMEOUT      (255)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in0_raw   (in0_raw),
        .in1_raw   (in1_raw),
        .enable    (enable),
        .in0_clean (in0_clean),
        .in1_clean (in1_clean),
        .in0_rise  (in0_rise),
        .in0_active(in0_active),
        .lost      (lost),
        .state     (state),
        .edge_count(edge_count)
    );

    always #5 clk = ~clk;

    typedef enum int {S_STATE, S_EC, S_ACT, S_LOST, S_RISE, S_C0, S_C1} sig_e;
    typedef struct {
        int   cyc;
        sig_e sig;
        int   val;
    } exp_t;

    exp_t sbq[$];
    int   edge_n = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t mon_e;
    int   mon_a;

    always @(posedge clk) edge_n++;

    function automatic void push(input int cyc, input sig_e s, input int v);
        exp_t e;
        int   i;
        e.cyc = cyc;
        e.sig = s;
        e.val = v;
        i = 0;
        while (i < sbq.size() && sbq[i].cyc <= cyc) i++;
        sbq.insert(i, e);
    endfunction

    function automatic int actual(input sig_e s);
        case (s)
            S_STATE: return int'(state);
            S_EC:    return int'(edge_count);
            S_ACT:   return int'(in0_active);
            S_LOST:  return int'(lost);
            S_RISE:  return int'(in0_rise);
            S_C0:    return int'(in0_clean);
            default: return int'(in1_clean);
        endcase
    endfunction

    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].cyc <= edge_n) begin
            mon_e = sbq.pop_front();
            checks++;
            if (mon_e.cyc < edge_n) begin
                errors++;
                $display("FAIL missed_%s cyc=%0d required=%0d", mon_e.sig.name(), mon_e.cyc, mon_e.val);
            end else begin
                mon_a = actual(mon_e.sig);
                if (mon_a != mon_e.val) begin
                    errors++;
                    $display("FAIL %s cyc=%0d actual=%0d required=%0d",
                             mon_e.sig.name(), mon_e.cyc, mon_a, mon_e.val);
                end
            end
        end
    end

    task automatic wait_to(input int n);
        while (edge_n < n) @(negedge clk);
    endtask

    // Square wave of period 20 on in0_raw; each raw rise reaches the counter 7 edges later.
    task automatic run_rises(input int n, input bit expect_lock, output int last_r);
        last_r = 0;
        for (int k = 1; k <= n; k++) begin
            repeat (10) @(negedge clk);
            in0_raw = 1'b1;
            last_r  = edge_n;
            push(edge_n + 7, S_EC, k);
            if (k == n && expect_lock) begin
                push(edge_n + 6, S_STATE, 1);
                push(edge_n + 7, S_STATE, 2);
                push(edge_n + 7, S_ACT, 0);
                push(edge_n + 8, S_ACT, 1);
            end
            repeat (10) @(negedge clk);
            in0_raw = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d pending=%0d", edge_n, sbq.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int r, t, x, z, p;
        rst_n   = 1'b0;
        in0_raw = 1'b0;
        in1_raw = 1'b0;
        enable  = 1'b0;
        push(2, S_STATE, 0); push(2, S_EC, 0);   push(2, S_ACT, 0); push(2, S_LOST, 0);
        push(2, S_RISE, 0);  push(2, S_C0, 0);   push(2, S_C1, 0);

        // Reset release, then in0 held high: clean after 5 edges, one rise pulse.
        wait_to(3);
        rst_n = 1'b1;
        push(4, S_STATE, 0);
        wait_to(5);
        in0_raw = 1'b1;
        push(9, S_C0, 0);    push(10, S_C0, 1);
        push(10, S_RISE, 0); push(11, S_RISE, 1); push(12, S_RISE, 0);
        push(12, S_EC, 0);   push(12, S_STATE, 0);

        // in1: 2-cycle glitch is filtered, 3-cycle pulse passes with 5-edge latency.
        wait_to(20);
        in1_raw = 1'b1;
        for (int i = 3; i <= 8; i++) push(20 + i, S_C1, 0);
        wait_to(22);
        in1_raw = 1'b0;
        wait_to(30);
        in1_raw = 1'b1;
        push(34, S_C1, 0); push(35, S_C1, 1); push(37, S_C1, 1); push(38, S_C1, 0);
        wait_to(33);
        in1_raw = 1'b0;

        // Enable and lock on 63 rises.
        wait_to(40);
        enable  = 1'b1;
        in0_raw = 1'b0;
        push(40, S_STATE, 0); push(41, S_STATE, 1);
        run_rises(63, 1'b1, r);

        // in0 stops: lost pulse once the gap timer reaches TIMEOUT.
        t = r + 263;
        push(t - 1, S_STATE, 2); push(t - 1, S_LOST, 0);
        push(t, S_STATE, 1);     push(t, S_LOST, 1);   push(t, S_EC, 0); push(t, S_ACT, 1);
        push(t + 1, S_LOST, 0);  push(t + 1, S_ACT, 0);

        // Rise coinciding with timer==TIMEOUT in ACQUIRE: counted, no timeout.
        wait_to(t + 249);
        in0_raw = 1'b1;
        push(t + 255, S_EC, 0);
        push(t + 256, S_EC, 1); push(t + 256, S_STATE, 1); push(t + 256, S_LOST, 0);
        push(t + 260, S_EC, 1); push(t + 260, S_STATE, 1);
        wait_to(t + 260);
        enable  = 1'b0;
        in0_raw = 1'b0;
        push(t + 261, S_STATE, 0); push(t + 261, S_EC, 0);

        // Relock, saturate the count, then async reset between edges.
        wait_to(t + 270);
        enable = 1'b1;
        run_rises(63, 1'b1, r);
        repeat (10) @(negedge clk);
        p = edge_n;
        in0_raw = 1'b1;
        push(p + 5, S_C0, 1); push(p + 7, S_EC, 63); push(p + 7, S_STATE, 2);
        wait_to(p + 10);
        x = edge_n;
        push(x, S_STATE, 2); push(x, S_ACT, 1); push(x, S_C0, 1);
        push(x + 1, S_STATE, 0); push(x + 1, S_ACT, 0); push(x + 1, S_EC, 0);
        push(x + 1, S_C0, 0);    push(x + 1, S_RISE, 0); push(x + 1, S_LOST, 0);
        @(posedge clk);
        #1;
        rst_n   = 1'b0;
        in0_raw = 1'b0;
        wait_to(x + 4);
        rst_n = 1'b1;
        z = edge_n;
        push(z + 1, S_STATE, 1); push(z + 1, S_EC, 0);
        run_rises(63, 1'b1, r);

        for (int i = 0; i < 500 && sbq.size() > 0; i++) @(negedge clk);
        while (sbq.size() > 0) begin
            mon_e = sbq.pop_front();
            checks++;
            errors++;
            $display("FAIL unchecked_%s cyc=%0d required=%0d", mon_e.sig.name(), mon_e.cyc, mon_e.val);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
